// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding and default parameters shared by debounce_pulse and its users
package debounce_pkg;
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b11,
    CHK_LO    = 2'b10
  } state_t;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser (clk, reset -> 0) carrying async d into the clk domain as q
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic sync1;
  always_ff @(posedge clk)
    if (reset) {q, sync1} <= '0;
    else {q, sync1} <= {sync1, d};
endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse: sync + debounce btn_in (clk, reset) into level with one-cycle rise/fall pulses
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  if (STABLE_CYCLES < 1 || STABLE_CYCLES >= 2 ** CNT_W) begin : g_bad_params
    $fatal(1, "debounce_pulse: STABLE_CYCLES out of range for CNT_W");
  end
  logic btn_s;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic level_nxt, rise_nxt, fall_nxt, hit;
  sync2 u_sync (
    .clk(clk),
    .reset(reset),
    .d(btn_in),
    .q(btn_s)
  );
  // cnt is 0 in the stable states, so a single compare covers STABLE_CYCLES=1 as well
  assign hit = cnt == LAST;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    level_nxt = level;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    case (state)
      STABLE_LO, CHK_HI: begin
        state_nxt = !btn_s ? STABLE_LO : hit ? STABLE_HI : CHK_HI;
        cnt_nxt = (!btn_s || hit) ? '0 : cnt + CNT_W'(1);
        level_nxt = btn_s && hit;
        rise_nxt = btn_s && hit;
      end
      STABLE_HI, CHK_LO: begin
        state_nxt = btn_s ? STABLE_HI : hit ? STABLE_LO : CHK_LO;
        cnt_nxt = (btn_s || hit) ? '0 : cnt + CNT_W'(1);
        level_nxt = btn_s || !hit;
        fall_nxt = !btn_s && hit;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= STABLE_LO;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      level <= level_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
endmodule
